// File: rtl/interp_pkg.sv
// interp_pkg: shared tap count, product types and per-phase tap sign masks for the interpolation filter
package interp_pkg;
  localparam int NUM_TAPS = 8;
  localparam int NUM_PHASES = 16;
  localparam int PROD_W = 32;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PROD_W:0] term_t;
  typedef prod_t prod_arr_t [NUM_TAPS];
  localparam logic [NUM_TAPS-1:0] SIGN_MASK [NUM_PHASES] = '{
    8'b0000_0000, 8'b1010_0101, 8'b1010_0101, 8'b1010_0101,
    8'b1010_0101, 8'b1010_0101, 8'b1010_0101, 8'b1010_0101,
    8'b1010_0101, 8'b1010_0101, 8'b1010_0101, 8'b1010_0101,
    8'b1010_0101, 8'b1010_0101, 8'b1010_0101, 8'b1010_0101
  };
  function automatic term_t apply_sign(input prod_t p, input logic neg);
    return neg ? -term_t'(p) : term_t'(p);
  endfunction
endpackage

// File: rtl/interp_clip.sv
// interp_clip: combinational round-shift / phase-0 bypass / optional clip used in the last stage
//   sum    : rounded 35-bit tap sum (or the raw centre product for phase 0)
//   bypass : phase 0, pass sum through without shifting
//   y      : 32-bit result, clipped to [0, 2^BIT_DEPTH-1] when INTERP_CLIP_EN is defined
module interp_clip #(
  parameter int SHIFT = 6,
  parameter int BIT_DEPTH = 10
) (
  input  logic signed [34:0] sum,
  input  logic               bypass,
  output logic signed [31:0] y
);
  logic signed [31:0] r;
  assign r = bypass ? 32'(sum) : 32'(sum >>> SHIFT);
`ifdef INTERP_CLIP_EN
  localparam logic signed [31:0] MAXV = 32'((1 << BIT_DEPTH) - 1);
  assign y = r < 0 ? '0 : (r > MAXV ? MAXV : r);
`else
  logic unused_bd;
  assign unused_bd = ^BIT_DEPTH;
  assign y = r;
`endif
endmodule

// File: rtl/interp_sum_round.sv
// interp_sum_round: 4-stage signed 8-tap sum, round, normalise shift and clip with valid/ready flow control
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake (in_ready is the global advance enable)
//   in_phase, in_prod0-7: fractional phase and tap product magnitudes
//   out_valid/out_ready : output sample handshake
//   out_sample/out_phase: signed result and its phase
//   INTERP_CLIP_EN      : when defined, results are clipped to the BIT_DEPTH sample range
module interp_sum_round
  import interp_pkg::*;
#(
  parameter int SHIFT = 6,
  parameter int BIT_DEPTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_phase,
  input  logic signed [31:0] in_prod0,
  input  logic signed [31:0] in_prod1,
  input  logic signed [31:0] in_prod2,
  input  logic signed [31:0] in_prod3,
  input  logic signed [31:0] in_prod4,
  input  logic signed [31:0] in_prod5,
  input  logic signed [31:0] in_prod6,
  input  logic signed [31:0] in_prod7,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_sample,
  output logic [3:0]         out_phase
);
  localparam logic signed [34:0] RND = 35'sd1 <<< (SHIFT - 1);
  prod_arr_t prod;
  term_t t [NUM_TAPS];
  logic adv, v1, v2, v3;
  logic [3:0] ph1, ph2, ph3;
  logic signed [32:0] p1 [4];
  logic signed [33:0] p2 [2];
  logic signed [34:0] s3;
  logic signed [31:0] res;
  assign prod = '{in_prod0, in_prod1, in_prod2, in_prod3, in_prod4, in_prod5, in_prod6, in_prod7};
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  // phase 0 routes only the centre product through the adder tree so it arrives unchanged
  always_comb
    for (int k = 0; k < NUM_TAPS; k++)
      t[k] = (in_phase == '0 && k != 3) ? '0 : apply_sign(prod[k], SIGN_MASK[in_phase][k]);
  interp_clip #(.SHIFT(SHIFT), .BIT_DEPTH(BIT_DEPTH)) u_clip (
    .sum(s3),
    .bypass(ph3 == '0),
    .y(res)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, v2, v3, out_valid} <= '0;
      {ph1, ph2, ph3, out_phase} <= '0;
      p1 <= '{default: '0};
      p2 <= '{default: '0};
      s3 <= '0;
      out_sample <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      ph1 <= in_phase;
      for (int k = 0; k < 4; k++) p1[k] <= t[2*k] + t[2*k+1];
      v2 <= v1;
      ph2 <= ph1;
      p2[0] <= 34'(p1[0]) + 34'(p1[1]);
      p2[1] <= 34'(p1[2]) + 34'(p1[3]);
      v3 <= v2;
      ph3 <= ph2;
      s3 <= 35'(p2[0]) + 35'(p2[1]) + (ph2 != '0 ? RND : '0);
      out_valid <= v3;
      out_phase <= ph3;
      out_sample <= res;
    end
endmodule

// File: tb/tb_interp_sum_round.sv
// tb_interp_sum_round: directed and randomized checks of interp_sum_round against an arithmetic reference model
module tb_interp_sum_round;
  import interp_pkg::*;
  localparam int SHIFT = 6;
  localparam int BIT_DEPTH = 10;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [3:0] in_phase = 0, out_phase;
  logic signed [31:0] out_sample;
  logic signed [31:0] pr [8];
  typedef struct {logic [31:0] s; logic [3:0] ph;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, out_cnt = 0, out_fires = 0, first_out = -1, last_out = -1;
  logic stalled = 0;
  logic [31:0] prev_sample;
  logic [3:0] prev_phase;
  logic f;
  int lat, sent;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  always #5 clk = ~clk;
  interp_sum_round #(.SHIFT(SHIFT), .BIT_DEPTH(BIT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_phase(in_phase),
    .in_prod0(pr[0]), .in_prod1(pr[1]), .in_prod2(pr[2]), .in_prod3(pr[3]),
    .in_prod4(pr[4]), .in_prod5(pr[5]), .in_prod6(pr[6]), .in_prod7(pr[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample), .out_phase(out_phase)
  );
  function automatic logic [31:0] ref_out(input logic [3:0] ph, input logic signed [31:0] p [8]);
    longint s = 0;
    longint r;
    logic signed [31:0] t;
    for (int k = 0; k < 8; k++) s += SIGN_MASK[ph][k] ? -longint'(p[k]) : longint'(p[k]);
    r = (ph == 0) ? longint'(p[3]) : (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    t = r[31:0];
`ifdef INTERP_CLIP_EN
    if (t < 0) t = 0;
    else if (t > 2 ** BIT_DEPTH - 1) t = 2 ** BIT_DEPTH - 1;
`endif
    return t;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask
  task automatic rand_prods(input bit wide);
    for (int k = 0; k < 8; k++) pr[k] = wide ? $signed($urandom) : $signed($urandom) >>> 10;
  endtask
  task automatic step(input logic v, input logic [3:0] ph, input logic ordy, output logic fired);
    exp_t e;
    in_valid = v;
    in_phase = ph;
    out_ready = ordy;
    #1;
    if (stalled) begin
      chk("stall_hold_sample", out_sample, prev_sample);
      chk("stall_hold_phase", 32'(out_phase), 32'(prev_phase));
    end
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (out_valid) begin
      out_cnt++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (out_valid && out_ready) begin
      out_fires++;
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL spurious_output observed=%0d expected=none", out_sample);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("model_sample", out_sample, e.s);
        chk("model_phase", 32'(out_phase), 32'(e.ph));
      end
    end
    fired = v && in_ready;
    if (fired) begin
      e.s = ref_out(ph, pr);
      e.ph = ph;
      q.push_back(e);
    end
    stalled = out_valid && !out_ready;
    prev_sample = out_sample;
    prev_phase = out_phase;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic single(input string tag, input logic [3:0] ph, input logic [31:0] expv);
    step(1, ph, 1, f);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step(0, 0, 1, f);
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sample"}, out_sample, expv);
    chk({tag, "_phase"}, 32'(out_phase), 32'(ph));
    step(0, 0, 1, f);
  endtask
  task automatic reset_counts();
    out_cnt = 0;
    out_fires = 0;
    first_out = -1;
    last_out = -1;
  endtask
  initial begin
    for (int k = 0; k < 8; k++) pr[k] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_out_phase", 32'(out_phase), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    pr = '{100, 400, 1100, 4000, 4000, 1100, 400, 100};
    single("halfpel", 8, 100);
    rand_prods(1);
    pr[3] = 513;
    single("bypass513", 0, 513);
    rand_prods(1);
    pr[3] = 2000;
`ifdef INTERP_CLIP_EN
    single("bypass2000", 0, 1023);
`else
    single("bypass2000", 0, 2000);
`endif
    pr = '{6400, 0, 0, 0, 0, 0, 0, 0};
`ifdef INTERP_CLIP_EN
    single("clip_neg", 8, 0);
`else
    single("clip_neg", 8, -32'sd100);
`endif
    reset_counts();
    for (int p = 0; p < 16; p++) begin
      rand_prods(p[0]);
      step(1, 4'(p), 1, f);
      chk("throughput_accept", 32'(f), 1);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, f);
    chk("throughput_count", out_cnt, 16);
    chk("throughput_contiguous", last_out - first_out + 1, 16);
    chk("throughput_drained", q.size(), 0);
    reset_counts();
    sent = 0;
    rand_prods(0);
    for (int i = 0; i < 200 && (sent < 10 || q.size() > 0); i++) begin
      step(sent < 10, 4'($urandom_range(0, 15)), pat[cyc % 4], f);
      if (f) begin
        sent++;
        rand_prods(0);
      end
    end
    chk("bp_sent", sent, 10);
    chk("bp_received", out_fires, 10);
    chk("bp_drained", q.size(), 0);
    for (int i = 0; i < 5; i++) begin
      rand_prods(1);
      step(1, 4'($urandom_range(1, 15)), 1, f);
    end
    #2;
    rst_n = 0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_out_sample", out_sample, 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    q.delete();
    stalled = 0;
    @(negedge clk);
    rst_n = 1;
    reset_counts();
    for (int i = 0; i < 8; i++) step(0, 0, 1, f);
    chk("midreset_no_stale", out_cnt, 0);
    for (int i = 0; i < 40; i++) begin
      rand_prods(i[0]);
      step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1), f);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, 1, f);
    chk("random_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
